// File: rtl/spi_sram_responder.sv
// SPI mode-0 serial SRAM responder: READ (0x03) / WRITE (0x02) with 24-bit address,
// auto-incrementing byte address, flop-based memory, all SPI inputs oversampled by clk.
module spi_sram_responder #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic cs_n,
  input  logic sck,
  input  logic si,
  output logic so,
  output logic so_oe
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWdata, StRdata, StIgnore} state_e;

  state_e                 r_state;
  logic                   r_cs_meta, r_cs_sync, r_cs_prev;
  logic                   r_sck_meta, r_sck_sync, r_sck_prev;
  logic                   r_si_meta, r_si_sync;
  logic [1:0]             r_fill;
  logic                   r_armed;
  logic [2:0]             r_bit_cnt;
  logic [2:0]             r_out_cnt;
  logic [1:0]             r_addr_byte;
  logic [7:0]             r_shift;
  logic [7:0]             r_out;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_is_read;
  logic [7:0]             r_mem [2**ADDR_BITS];

  logic                   w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic [7:0]             w_byte;
  logic [7:0]             w_rd_byte;
  logic                   w_wr_en;

  assign w_sck_rise = r_sck_sync & ~r_sck_prev;
  assign w_sck_fall = ~r_sck_sync & r_sck_prev;
  // A falling cs_n only counts once a real high level has been seen since reset, so a
  // transaction already under way when reset is released is skipped entirely.
  assign w_cs_fall  = ~r_cs_sync & r_cs_prev & r_armed;
  assign w_cs_rise  = r_cs_sync & ~r_cs_prev;
  assign w_byte     = {r_shift[6:0], r_si_sync};
  assign w_rd_byte  = r_mem[r_addr];
  // Independent of cs_n so a byte finishing on the same clk as cs_n rising still lands.
  assign w_wr_en    = ena & (r_state == StWdata) & w_sck_rise & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cs_meta   <= 1'b1;
      r_cs_sync   <= 1'b1;
      r_cs_prev   <= 1'b1;
      r_sck_meta  <= 1'b0;
      r_sck_sync  <= 1'b0;
      r_sck_prev  <= 1'b0;
      r_si_meta   <= 1'b0;
      r_si_sync   <= 1'b0;
      r_fill      <= 2'b00;
      r_armed     <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_out_cnt   <= 3'd0;
      r_addr_byte <= 2'd0;
      r_shift     <= 8'h00;
      r_out       <= 8'h00;
      r_addr      <= '0;
      r_is_read   <= 1'b0;
      so          <= 1'b0;
      so_oe       <= 1'b0;
    end else if (ena) begin
      r_cs_meta  <= cs_n;
      r_cs_sync  <= r_cs_meta;
      r_cs_prev  <= r_cs_sync;
      r_sck_meta <= sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_si_meta  <= si;
      r_si_sync  <= r_si_meta;
      r_fill     <= {r_fill[0], 1'b1};
      if (r_fill[1] && r_cs_sync) r_armed <= 1'b1;

      if (w_cs_rise) begin
        r_state   <= StIdle;
        r_bit_cnt <= 3'd0;
        r_shift   <= 8'h00;
        so        <= 1'b0;
        so_oe     <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_cs_fall) begin
              r_state     <= StCmd;
              r_bit_cnt   <= 3'd0;
              r_out_cnt   <= 3'd0;
              r_addr_byte <= 2'd0;
            end
          end
          StCmd: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (w_byte == 8'h03) begin
                  r_state   <= StAddr;
                  r_is_read <= 1'b1;
                end else if (w_byte == 8'h02) begin
                  r_state   <= StAddr;
                  r_is_read <= 1'b0;
                end else begin
                  r_state   <= StIgnore;
                end
              end
            end
          end
          StAddr: begin
            if (w_sck_rise) begin
              // Shifting through an ADDR_BITS-wide register keeps only the low address bits.
              r_addr    <= {r_addr[ADDR_BITS-2:0], r_si_sync};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_addr_byte <= r_addr_byte + 2'd1;
                if (r_addr_byte == 2'd2) r_state <= r_is_read ? StRdata : StWdata;
              end
            end
          end
          StWdata: begin
            if (w_sck_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_addr <= r_addr + 1'b1;
            end
          end
          StRdata: begin
            if (w_sck_fall) begin
              if (r_out_cnt == 3'd0) begin
                r_out     <= w_rd_byte;
                so        <= w_rd_byte[7];
                so_oe     <= 1'b1;
                r_addr    <= r_addr + 1'b1;
                r_out_cnt <= 3'd1;
              end else begin
                so        <= r_out[6];
                r_out     <= {r_out[6:0], 1'b0};
                r_out_cnt <= r_out_cnt + 3'd1;
              end
            end
          end
          StIgnore: begin
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_addr] <= w_byte;
  end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: directed vector table, random write/read
// traffic against an array model of the SRAM, and hand-written abort/reset/hold sequences.
module tb_spi_sram_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic cs_n = 1'b1;
  logic sck = 1'b0;
  logic si = 1'b0;
  logic so, so_oe;

  always #5 clk = ~clk;

  spi_sram_responder #(.ADDR_BITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .cs_n  (cs_n),
    .sck   (sck),
    .si    (si),
    .so    (so),
    .so_oe (so_oe)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] mem_m [256];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic oe_hi;
  logic oe_lo;

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    int          nb;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: data set while low, outputs sampled just before the rising edge.
  task automatic sck_bit(input logic b, output logic so_s, output logic oe_s);
    si = b;
    wait_clks(4);
    so_s = so;
    oe_s = so_oe;
    sck = 1'b1;
    wait_clks(4);
    sck = 1'b0;
  endtask

  task automatic byte_w(input logic [7:0] b);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(b[i], s, o);
      if (o) oe_hi = 1'b1;
    end
  endtask

  task automatic byte_r(output logic [7:0] b);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(1'b0, s, o);
      b[i] = s;
      if (!o) oe_lo = 1'b1;
    end
  endtask

  task automatic spi_begin();
    cs_n = 1'b0;
    wait_clks(4);
  endtask

  task automatic spi_end();
    wait_clks(4);
    cs_n = 1'b1;
    wait_clks(6);
  endtask

  task automatic do_write(input logic [23:0] a, input bit upd);
    logic [7:0] idx;
    oe_hi = 1'b0;
    spi_begin();
    byte_w(8'h02);
    byte_w(a[23:16]);
    byte_w(a[15:8]);
    byte_w(a[7:0]);
    foreach (tx_q[i]) byte_w(tx_q[i]);
    spi_end();
    if (upd) begin
      foreach (tx_q[i]) begin
        idx = a[7:0] + 8'(i);
        mem_m[idx] = tx_q[i];
      end
    end
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [7:0] b;
    oe_hi = 1'b0;
    oe_lo = 1'b0;
    rx_q.delete();
    spi_begin();
    byte_w(8'h03);
    byte_w(a[23:16]);
    byte_w(a[15:8]);
    byte_w(a[7:0]);
    for (int i = 0; i < n; i++) begin
      byte_r(b);
      rx_q.push_back(b);
    end
    spi_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  idx;
    logic [23:0] a;
    logic        s, o;
    int          n, errs;

    vecs[0] = '{wr: 1'b1, addr: 24'h000010, nb: 1, d0: 8'hA5, d1: 8'h00};
    vecs[1] = '{wr: 1'b0, addr: 24'h000010, nb: 1, d0: 8'hA5, d1: 8'h00};
    vecs[2] = '{wr: 1'b1, addr: 24'h0000FF, nb: 2, d0: 8'h11, d1: 8'h22};
    vecs[3] = '{wr: 1'b0, addr: 24'h000000, nb: 1, d0: 8'h22, d1: 8'h00};
    vecs[4] = '{wr: 1'b0, addr: 24'h0000FF, nb: 2, d0: 8'h11, d1: 8'h22};
    vecs[5] = '{wr: 1'b1, addr: 24'hABCD42, nb: 1, d0: 8'h3C, d1: 8'h00};
    vecs[6] = '{wr: 1'b0, addr: 24'h000042, nb: 1, d0: 8'h3C, d1: 8'h00};

    wait_clks(3);
    chk("reset_so", 32'(so), 32'd0);
    chk("reset_so_oe", 32'(so_oe), 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    // Give every location a known value so later checks never depend on power-up contents.
    tx_q.delete();
    for (int i = 0; i < 256; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    do_write(24'h000000, 1'b1);
    chk("fill_so_oe", 32'(oe_hi), 32'd0);

    foreach (vecs[v]) begin
      if (vecs[v].wr) begin
        tx_q.delete();
        tx_q.push_back(vecs[v].d0);
        if (vecs[v].nb > 1) tx_q.push_back(vecs[v].d1);
        do_write(vecs[v].addr, 1'b1);
        chk($sformatf("vec%0d_wr_oe", v), 32'(oe_hi), 32'd0);
      end else begin
        do_read(vecs[v].addr, vecs[v].nb);
        chk($sformatf("vec%0d_rd0", v), 32'(rx_q[0]), 32'(vecs[v].d0));
        if (vecs[v].nb > 1) chk($sformatf("vec%0d_rd1", v), 32'(rx_q[1]), 32'(vecs[v].d1));
        chk($sformatf("vec%0d_addr_oe", v), 32'(oe_hi), 32'd0);
        chk($sformatf("vec%0d_data_oe", v), 32'(oe_lo), 32'd0);
        chk($sformatf("vec%0d_idle_oe", v), 32'(so_oe), 32'd0);
      end
    end

    for (int t = 0; t < 10; t++) begin
      a = 24'($urandom);
      n = $urandom_range(1, 3);
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
      do_write(a, 1'b1);
      a = 24'($urandom);
      n = $urandom_range(1, 3);
      do_read(a, n);
      for (int i = 0; i < n; i++) begin
        idx = a[7:0] + 8'(i);
        chk($sformatf("rand%0d_byte%0d", t, i), 32'(rx_q[i]), 32'(mem_m[idx]));
      end
      chk($sformatf("rand%0d_oe", t), 32'(oe_lo), 32'd0);
    end

    // Unknown command followed by 40 SCK cycles.
    oe_hi = 1'b0;
    spi_begin();
    byte_w(8'h9F);
    for (int i = 0; i < 5; i++) byte_w(8'($urandom_range(0, 255)));
    spi_end();
    chk("ignore_oe", 32'(oe_hi), 32'd0);

    // Abort after 5 data bits of a write.
    spi_begin();
    byte_w(8'h02);
    byte_w(8'h00);
    byte_w(8'h00);
    byte_w(8'h05);
    idx = ~mem_m[5];
    for (int i = 7; i > 2; i--) sck_bit(idx[i], s, o);
    spi_end();
    chk("abort_so_oe", 32'(so_oe), 32'd0);
    do_read(24'h000005, 1);
    chk("abort_mem5", 32'(rx_q[0]), 32'(mem_m[5]));

    // Reset mid-read, then a stray transaction with cs_n never released must be ignored.
    spi_begin();
    byte_w(8'h03);
    byte_w(8'h00);
    byte_w(8'h00);
    byte_w(8'h10);
    for (int i = 0; i < 3; i++) sck_bit(1'b0, s, o);
    chk("midread_oe_before_reset", 32'(o), 32'd1);
    wait_clks(1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_so_oe", 32'(so_oe), 32'd0);
    chk("reset_async_so", 32'(so), 32'd0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    oe_hi = 1'b0;
    byte_w(8'h02);
    byte_w(8'h00);
    byte_w(8'h00);
    byte_w(8'h05);
    byte_w(~mem_m[5]);
    spi_end();
    chk("post_reset_oe", 32'(oe_hi), 32'd0);
    do_read(24'h000005, 1);
    chk("post_reset_mem5", 32'(rx_q[0]), 32'(mem_m[5]));

    // Whole write with ena low.
    ena = 1'b0;
    tx_q.delete();
    tx_q.push_back(~mem_m[8'h20]);
    do_write(24'h000020, 1'b0);
    chk("hold_oe", 32'(oe_hi), 32'd0);
    ena = 1'b1;
    wait_clks(4);
    do_read(24'h000020, 1);
    chk("hold_mem20", 32'(rx_q[0]), 32'(mem_m[8'h20]));

    do_read(24'h000000, 256);
    errs = 0;
    for (int i = 0; i < 256; i++) if (rx_q[i] !== mem_m[i]) errs++;
    chk("dump_mismatches", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 8, giving the internal memory depth (2^ADDR_BITS bytes).
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all state on posedge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ena, input, 1 bit: when low, all state holds and SCK/CS edges are not acted on.
REQ-005 The block SHALL have port cs_n, input, 1 bit: SPI chip select, active low.
REQ-006 The block SHALL have port sck, input, 1 bit: SPI clock, mode 0, asynchronous to clk.
REQ-007 The block SHALL have port si, input, 1 bit: serial data in (controller to SRAM), MSB first.
REQ-008 The block SHALL have port so, output, 1 bit: serial data out (SRAM to controller), MSB first.
REQ-009 The block SHALL have port so_oe, output, 1 bit: high only while read data is driven.

Function
REQ-010 The block SHALL pass cs_n, sck and si through 2-flop synchronizers and detect SCK rise/fall from the synchronized value; SCK high and low phases SHALL each be at least 4 clk periods.
REQ-011 On each synchronized SCK rising edge with cs_n low, the block SHALL sample si into an 8-bit shift register and increment a 3-bit bit counter (wraps 7->0).
REQ-012 The FSM SHALL have states IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
REQ-013 IDLE->CMD on synchronized cs_n falling; bit counter cleared.
REQ-014 CMD: after 8 bits, 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
REQ-015 ADDR: SHALL shift in 24 address bits; only the low ADDR_BITS are kept, upper bits discarded; then -> RDATA or WDATA.
REQ-016 WDATA: on each 8th rising edge, the assembled byte SHALL be written to mem[addr] and addr SHALL increment modulo 2^ADDR_BITS (255->0 at default).
REQ-017 RDATA: on the SCK falling edge after the last address bit, the block SHALL load mem[addr] into the output shift register, drive bit 7 on so and set so_oe.
REQ-018 RDATA: each subsequent falling edge SHALL shift the next bit onto so; after the 8th bit the next byte SHALL be loaded from addr+1, with wrap per REQ-016.
REQ-019 so/so_oe SHALL update on the clk cycle after the synchronized SCK falling edge is detected.
REQ-020 IGNORE SHALL discard all SCK activity and keep so_oe low until cs_n rises.
REQ-021 Synchronized cs_n rising in any state SHALL return to IDLE the next clk: so_oe=0, so=0, partial write byte discarded, no memory write.
REQ-022 A write completing on the same clk as cs_n rising SHALL still be committed.
REQ-023 Memory SHALL be 2^ADDR_BITS x 8 flops, not cleared by reset.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, so=0, so_oe=0, bit counter=0, addr=0, shift registers=0 and synchronizers to the idle value (cs_n=1, sck=0), including mid-transaction.
REQ-025 After rst_n deasserts, a transaction already in progress (cs_n low) SHALL be ignored until cs_n rises and falls again.

Verification
REQ-026 Write then read: WRITE 0x02, addr 0x000010, data 0xA5; then READ 0x03, addr 0x000010 -> so returns 0xA5 MSB first, so_oe high only during the 8 data bits.
REQ-027 Wrap: WRITE at 0x0000FF with bytes 0x11,0x22 -> read at 0x000000 returns 0x22, read at 0x0000FF returns 0x11.
REQ-028 Upper address ignored: WRITE at 0xABCD42, data 0x3C -> READ at 0x000042 returns 0x3C.
REQ-029 Unknown command 0x9F followed by 40 SCK cycles -> so_oe stays 0 and memory is unchanged.
REQ-030 Abort: WRITE at 0x05, cs_n raised after 5 data bits -> mem[0x05] is unchanged and state is IDLE; assert rst_n low mid-READ -> so_oe=0 immediately.
REQ-031 Hold: ena=0 during an entire WRITE sequence -> no memory change and so_oe=0.
